axi4lite_slave_regfile: RTL and testbench
=========================================

AXI4LITE_SLAVE_REGFILE -- requirements
Module: axi4lite_slave_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of 32-bit registers, occupying byte addresses 0 to 4*NUM_REGS-1.
REQ-004 ACLK  input  1  single clock; all logic is rising-edge triggered.
REQ-005 ARESETN  input  1  reset, asynchronous and active-low.
REQ-006 AWADDR input ADDR_WIDTH, AWVALID input 1, AWREADY output 1: write address channel.
REQ-007 WDATA input 32, WSTRB input 4, WVALID input 1, WREADY output 1: write data channel.
REQ-008 BRESP output 2, BVALID output 1, BREADY input 1: write response channel.
REQ-009 ARADDR input ADDR_WIDTH, ARVALID input 1, ARREADY output 1: read address channel.
REQ-010 RDATA output 32, RRESP output 2, RVALID output 1, RREADY input 1: read data channel.

Function
REQ-011 Write FSM SHALL have states W_IDLE, W_RESP; read FSM SHALL have states R_IDLE, R_DATA; the two FSMs SHALL operate independently.
REQ-012 In W_IDLE, AWREADY SHALL be 1 until AW is accepted and WREADY SHALL be 1 until W is accepted; AW and W may be accepted in either order or in the same cycle.
REQ-013 An accepted AW or W SHALL be latched, and its READY SHALL drop the next cycle until the write completes.
REQ-014 At the edge where the second of AW/W is accepted, the write SHALL commit and the FSM SHALL enter W_RESP with BVALID=1 from the next cycle.
REQ-015 In W_RESP, BVALID and BRESP SHALL hold stable until BREADY=1; on that edge the FSM SHALL return to W_IDLE with AWREADY=WREADY=1 the next cycle.
REQ-016 In R_IDLE, ARREADY SHALL be 1; on AR handshake RDATA/RRESP SHALL be registered, RVALID=1 the next cycle, and ARREADY=0 while in R_DATA.
REQ-017 In R_DATA, RVALID, RDATA and RRESP SHALL hold stable until RREADY=1, then the FSM SHALL return to R_IDLE.
REQ-018 Register index SHALL be addr[ADDR_WIDTH-1:2]; addr[1:0] SHALL be ignored, so unaligned accesses hit the containing word.
REQ-019 Address >= 4*NUM_REGS SHALL return SLVERR (2'b10), with no register write and RDATA=0; in-range accesses SHALL return OKAY (2'b00).
REQ-020 A read and a write to the same register committing on the same edge SHALL return the pre-write value.
REQ-021 Back-to-back transactions SHALL sustain one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held at 1.
REQ-022 VALID deasserted before handshake SHALL NOT be considered an accepted transfer.

Reset
REQ-023 While ARESETN=0: all registers=0, FSMs in W_IDLE/R_IDLE, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, AWREADY=WREADY=ARREADY=0.
REQ-024 READY outputs SHALL rise to 1 on the first ACLK edge after ARESETN deasserts.
REQ-025 Reset asserted mid-transaction SHALL discard all latched AW/W/AR state and pending responses immediately.

Configuration
REQ-026 Macro AXIL_WSTRB_EN defined: only bytes with WSTRB[i]=1 SHALL be written (byte i = WDATA[8i+7:8i]).
REQ-027 AXIL_WSTRB_EN undefined: WSTRB SHALL be ignored and the full 32-bit word written.

Verification
REQ-028 Reset, write AW=0x04 and W=0xDEADBEEF (WSTRB=0xF) in the same cycle, BREADY=1 -> BVALID 1 cycle later with BRESP=00; read 0x04 -> RDATA=0xDEADBEEF, RRESP=00.
REQ-029 W sent 3 cycles before AW=0x08 with data 0x12345678 -> WREADY drops after the W handshake, write commits on the AW edge, and a read of 0x08 returns 0x12345678.
REQ-030 Write 0x20 (out of range with NUM_REGS=8) -> BRESP=10, all registers unchanged; read 0x20 -> RRESP=10, RDATA=0.
REQ-031 Register 0x0C=0xFFFFFFFF, then write 0x00000000 with WSTRB=0x3 -> read 0x0C returns 0xFFFF0000 with AXIL_WSTRB_EN defined, and 0x00000000 without it.
REQ-032 Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable and AWREADY=WREADY=0 throughout; assert ARESETN=0 during R_DATA -> RVALID=0 immediately and all registers read back 0 afterward.

Source files
------------

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave with NUM_REGS x 32-bit registers and independent write/read FSMs.
// Optional macro AXIL_WSTRB_EN enables per-byte write strobes; undefined means full-word writes.
module axi4lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    w_state_dbg,
    output logic                    r_state_dbg
);

    // Handshake rule: a transfer happens on a rising ACLK edge where VALID and READY are both 1;
    // VALID dropped before such an edge transfers nothing.

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                  ready_en_q;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [SEL_W-1:0]      wr_sel, rd_sel;
    logic                  wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         byte_en;
    logic [1:0]            unused_addr_bits;

    assign unused_addr_bits = AWADDR[1:0] ^ ARADDR[1:0];

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Either channel may arrive first; the late one is taken straight from the bus.
    assign wr_idx  = aw_done_q ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
    assign wr_data = w_done_q ? wdata_q : WDATA;
    assign wr_sel  = wr_idx[SEL_W-1:0];
    assign wr_ok   = wr_idx < IDX_W'(NUM_REGS);
    assign commit  = (w_state_q == W_IDLE) && (aw_done_q || aw_hs) && (w_done_q || w_hs);

    assign rd_idx = ARADDR[ADDR_WIDTH-1:2];
    assign rd_sel = rd_idx[SEL_W-1:0];
    assign rd_ok  = rd_idx < IDX_W'(NUM_REGS);

`ifdef AXIL_WSTRB_EN
    logic [NB-1:0] wstrb_q, wstrb_d;

    assign wstrb_d = w_hs ? WSTRB : wstrb_q;
    assign byte_en = w_done_q ? wstrb_q : WSTRB;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstrb_q <= '0;
        end else begin
            wstrb_q <= wstrb_d;
        end
    end
`else
    logic unused_wstrb;

    assign unused_wstrb = ^WSTRB;
    assign byte_en      = '1;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            ready_en_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            ready_en_q <= 1'b1;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: if (commit) w_state_d = W_RESP;
            W_RESP: if (BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) r_state_d = R_DATA;
            R_DATA: if (RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (aw_hs) begin
            aw_done_d = 1'b1;
            aw_idx_d  = AWADDR[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_done_d = 1'b1;
            wdata_d  = WDATA;
        end
        if (commit) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
                for (int b = 0; b < NB; b++) begin
                    if (byte_en[b]) begin
                        regs_d[wr_sel][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Reads sample regs_q, so a write committing on the same edge is not yet visible.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            rdata_d = rd_ok ? regs_q[rd_sel] : '0;
            rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_comb begin
        AWREADY     = ready_en_q && (w_state_q == W_IDLE) && !aw_done_q;
        WREADY      = ready_en_q && (w_state_q == W_IDLE) && !w_done_q;
        BVALID      = (w_state_q == W_RESP);
        BRESP       = bresp_q;
        ARREADY     = ready_en_q && (r_state_q == R_IDLE);
        RVALID      = (r_state_q == R_DATA);
        RDATA       = rdata_q;
        RRESP       = rresp_q;
        w_state_dbg = w_state_q;
        r_state_dbg = r_state_q;
    end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed bench for axi4lite_slave_regfile: drivers push expected B/R responses into
// queues that a negedge monitor pops and compares.
module tb_axi4lite_slave_regfile;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        w_state_dbg;
    logic        r_state_dbg;

    int errors = 0;
    int checks = 0;

    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];

    axi4lite_slave_regfile dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    // ---------------- clock ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (BVALID && BREADY) begin
                if (b_exp_q.size() == 0) begin
                    check("b_unexpected", 64'(BRESP), 64'hFFFF);
                end else begin
                    check("bresp", 64'(BRESP), 64'(b_exp_q.pop_front()));
                end
            end
            if (RVALID && RREADY) begin
                if (r_exp_q.size() == 0) begin
                    check("r_unexpected", {30'd0, RRESP, RDATA}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    check("rresp_rdata", {30'd0, RRESP, RDATA}, 64'(r_exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks (entered #1 after a rising edge) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input logic [1:0] exp_resp,
                            input bit wait_b);
        bit aw_acc = 0;
        bit w_acc = 0;
        bit aw_ok, w_ok;
        int cyc = 0;
        int n = 0;
        b_exp_q.push_back(exp_resp);
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        while (!(aw_acc && w_acc) && cyc < 40) begin
            AWVALID = (cyc >= aw_dly) && !aw_acc;
            WVALID  = (cyc >= w_dly) && !w_acc;
            @(negedge ACLK);
            aw_ok = AWVALID && AWREADY;
            w_ok  = WVALID && WREADY;
            if (w_acc && !aw_acc) check("wready_drop", 64'(WREADY), 64'd0);
            if (aw_acc && !w_acc) check("awready_drop", 64'(AWREADY), 64'd0);
            if (aw_acc || w_acc) check("no_early_bvalid", 64'(BVALID), 64'd0);
            @(posedge ACLK);
            #1;
            aw_acc = aw_acc | aw_ok;
            w_acc  = w_acc | w_ok;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (!(aw_acc && w_acc)) begin
            check("aw_w_timeout", 64'(cyc), 64'd0);
        end else begin
            @(negedge ACLK);
            check("b_latency", 64'(BVALID), 64'd1);
            if (wait_b) begin
                while (!(BVALID && BREADY) && n < 40) begin
                    @(negedge ACLK);
                    n++;
                end
                if (n >= 40) check("b_timeout", 64'(n), 64'd0);
            end
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit acc = 0;
        int cyc = 0;
        int n = 0;
        r_exp_q.push_back({exp_resp, exp_data});
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (!acc && cyc < 40) begin
            @(negedge ACLK);
            acc = ARVALID && ARREADY;
            @(posedge ACLK);
            #1;
            cyc++;
        end
        ARVALID = 1'b0;
        if (!acc) begin
            check("ar_timeout", 64'(cyc), 64'd0);
        end else begin
            @(negedge ACLK);
            check("r_latency", 64'(RVALID), 64'd1);
            check("arready_low", 64'(ARREADY), 64'd0);
            while (!(RVALID && RREADY) && n < 40) begin
                @(negedge ACLK);
                n++;
            end
            if (n >= 40) check("r_timeout", 64'(n), 64'd0);
            @(posedge ACLK);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] exp_regs [8];
    logic [31:0] exp_strb;
    int          k;

    initial begin
        ARESETN = 1'b0;
        AWADDR = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        ARADDR = '0; ARVALID = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;

        // Reset values
        repeat (2) @(negedge ACLK);
        check("rst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
        check("rst_valid", {62'd0, BVALID, RVALID}, 64'd0);
        check("rst_resp_data", {30'd0, BRESP, RRESP, RDATA}, 64'd0);
        check("rst_fsm", {62'd0, w_state_dbg, r_state_dbg}, 64'd0);
        ARESETN = 1'b1;
        #1;
        check("ready_before_edge", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
        @(posedge ACLK);
        #1;
        check("ready_after_edge", {61'd0, AWREADY, WREADY, ARREADY}, 64'h7);

        // AW and W together, then read back
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 1);
        do_read(32'h04, 32'hDEADBEEF, 2'b00);

        // W leads AW by 3 cycles
        do_write(32'h08, 32'h12345678, 4'hF, 3, 0, 2'b00, 1);
        do_read(32'h08, 32'h12345678, 2'b00);

        // Out of range write and read; registers untouched
        do_write(32'h20, 32'hA5A5A5A5, 4'hF, 0, 0, 2'b10, 1);
        do_read(32'h20, 32'h0, 2'b10);
        do_read(32'h1000_0004, 32'h0, 2'b10);
        exp_regs = '{32'h0, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            do_read(32'(i * 4), exp_regs[i], 2'b00);
        end
        do_read(32'h06, 32'hDEADBEEF, 2'b00);

        // Byte strobes
`ifdef AXIL_WSTRB_EN
        exp_strb = 32'hFFFF0000;
`else
        exp_strb = 32'h00000000;
`endif
        do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 1);
        do_write(32'h0C, 32'h00000000, 4'h3, 0, 0, 2'b00, 1);
        do_read(32'h0C, exp_strb, 2'b00);

        // Backpressure on B; AW leads W, unaligned address hits register 4
        BREADY = 1'b0;
        do_write(32'h13, 32'h0BADF00D, 4'hF, 0, 2, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bvalid_hold", 64'(BVALID), 64'd1);
            check("bresp_hold", 64'(BRESP), 64'd0);
            check("ready_low_in_resp", {62'd0, AWREADY, WREADY}, 64'd0);
            @(posedge ACLK);
            #1;
        end
        BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        check("ready_after_b", {62'd0, AWREADY, WREADY}, 64'h3);
        do_read(32'h10, 32'h0BADF00D, 2'b00);

        // Read and write of the same register on the same edge
        fork
            do_write(32'h04, 32'hCAFEF00D, 4'hF, 0, 0, 2'b00, 1);
            do_read(32'h04, 32'hDEADBEEF, 2'b00);
        join
        do_read(32'h04, 32'hCAFEF00D, 2'b00);

        // Reset while a read response is pending
        RREADY = 1'b0;
        ARADDR = 32'h04;
        ARVALID = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge ACLK);
            if (ARVALID && ARREADY) k = 100;
            else k++;
            @(posedge ACLK);
            #1;
        end
        ARVALID = 1'b0;
        check("ar_accept_pre_reset", 64'(k), 64'd100);
        @(negedge ACLK);
        check("rvalid_pre_reset", 64'(RVALID), 64'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("rvalid_async_clr", 64'(RVALID), 64'd0);
        check("rdata_async_clr", 64'(RDATA), 64'd0);
        b_exp_q.delete();
        r_exp_q.delete();
        repeat (2) @(negedge ACLK);
        check("ready_in_reset", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
        ARESETN = 1'b1;
        RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            do_read(32'(i * 4), 32'h0, 2'b00);
        end

        repeat (3) @(posedge ACLK);
        #1;
        check("b_queue_empty", 64'(b_exp_q.size()), 64'd0);
        check("r_queue_empty", 64'(r_exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL global_timeout: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
